// File: rtl/tag_reader.sv
// tag_reader: read side of the 128-bit tag register.
// EMIT streams the stored tag out MSB-word first; VERIFY compares it word by
// word against a received tag. Every word is always consumed, so the
// verification time does not depend on where a mismatch occurs.
module tag_reader #(
   parameter int unsigned WORD_W = 32
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic [127:0]      tag_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   input  logic [WORD_W-1:0] rx_word_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              tag_ok_o
);

   localparam int unsigned NB_WORDS = 128 / WORD_W;
   localparam int unsigned CNT_W    = $clog2(NB_WORDS) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [127:0]       shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mismatch_q, mismatch_d;
   logic               mode_q, mode_d;
   logic               tag_ok_q, tag_ok_d;
   logic [WORD_W-1:0]  head;

   assign head = shreg_q[127 -: WORD_W];

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         cnt_q      <= '0;
         mismatch_q <= 1'b0;
         mode_q     <= 1'b0;
         tag_ok_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         mismatch_q <= mismatch_d;
         mode_q     <= mode_d;
         tag_ok_q   <= tag_ok_d;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      mismatch_d = mismatch_q;
      mode_d     = mode_q;
      tag_ok_d   = tag_ok_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               shreg_d    = tag_i;
               cnt_d      = '0;
               mismatch_d = 1'b0;
               tag_ok_d   = 1'b0;
               mode_d     = mode_i;
               state_d    = mode_i ? CHECK : SEND;
            end
         end
         SEND: begin
            if (word_ready_i) begin
               shreg_d = shreg_q << WORD_W;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) state_d = DONE;
            end
         end
         CHECK: begin
            if (rx_valid_i) begin
               mismatch_d = mismatch_q | (|(rx_word_i ^ head));
               shreg_d    = shreg_q << WORD_W;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) state_d = DONE;
            end
         end
         DONE: begin
            // mismatch_q already includes the final word here.
            tag_ok_d = mode_q & ~mismatch_q;
            shreg_d  = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      word_o       = '0;
      word_valid_o = 1'b0;
      rx_ready_o   = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      unique case (state_q)
         IDLE: ;
         SEND: begin
            word_valid_o = 1'b1;
            word_o       = head;
            busy_o       = 1'b1;
         end
         CHECK: begin
            rx_ready_o = 1'b1;
            busy_o     = 1'b1;
         end
         DONE: begin
            done_o = 1'b1;
            busy_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign tag_ok_o = tag_ok_q;

endmodule

// File: tb/tb_tag_reader.sv
// Directed testbench for tag_reader (WORD_W = 32) with a scoreboard queue
// of expected emitted words and expected verify results.
module tb_tag_reader;

   localparam int unsigned W = 32;
   localparam int unsigned NW = 128 / W;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          start_i;
   logic          mode_i;
   logic [127:0]  tag_i;
   logic [W-1:0]  word_o;
   logic          word_valid_o;
   logic          word_ready_i;
   logic [W-1:0]  rx_word_i;
   logic          rx_valid_i;
   logic          rx_ready_o;
   logic          busy_o;
   logic          done_o;
   logic          tag_ok_o;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   bit           ok_q[$];

   localparam logic [127:0] T  = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [127:0] T2 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;

   tag_reader #(.WORD_W(W)) dut (
      .clock_i      (clk),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .mode_i       (mode_i),
      .tag_i        (tag_i),
      .word_o       (word_o),
      .word_valid_o (word_valid_o),
      .word_ready_i (word_ready_i),
      .rx_word_i    (rx_word_i),
      .rx_valid_i   (rx_valid_i),
      .rx_ready_o   (rx_ready_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .tag_ok_o     (tag_ok_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_word_o"}, word_o, '0);
      chk({tag, "_word_valid"}, word_valid_o, 1'b0);
      chk({tag, "_rx_ready"}, rx_ready_o, 1'b0);
      chk({tag, "_busy"}, busy_o, 1'b0);
      chk({tag, "_done"}, done_o, 1'b0);
      chk({tag, "_tag_ok"}, tag_ok_o, 1'b0);
   endtask

   // EMIT run: optional stall of stall_n cycles on word stall_idx.
   task automatic run_emit(input logic [127:0] t, input int stall_idx, input int stall_n,
                           output int done_cyc);
      int c, idx, stalls;
      start_i = 1'b1; mode_i = 1'b0; tag_i = t; word_ready_i = 1'b1;
      for (int k = 0; k < int'(NW); k++) exp_q.push_back(t[127 - k*W -: W]);
      tick();
      start_i = 1'b0;
      c = 1; idx = 0; stalls = stall_n; done_cyc = -1;
      while (c < 60) begin
         if (done_o) begin done_cyc = c; break; end
         if (c == 1) chk("emit_tag_ok_cleared", tag_ok_o, 1'b0);
         chk("emit_valid", word_valid_o, 1'b1);
         if (exp_q.size() == 0) begin
            chk("emit_extra_word", word_valid_o, 1'b0);
            break;
         end
         if (idx == stall_idx && stalls > 0) begin
            word_ready_i = 1'b0;
            stalls--;
            chk("emit_hold", word_o, exp_q[0]);
         end else begin
            word_ready_i = 1'b1;
            chk($sformatf("emit_word%0d", idx), word_o, exp_q.pop_front());
            idx++;
         end
         tick();
         c++;
      end
      word_ready_i = 1'b1;
      if (done_cyc < 0) chk("emit_done_seen", done_o, 1'b1);
      exp_q.delete();
      chk("emit_done_busy", busy_o, 1'b1);
      chk("emit_done_no_valid", word_valid_o, 1'b0);
      tick();
      chk("emit_done_pulse", done_o, 1'b0);
      chk("emit_after_busy", busy_o, 1'b0);
      chk("emit_tag_ok", tag_ok_o, 1'b0);
   endtask

   // VERIFY run: optional 1-cycle gaps; optional start pulses during CHECK and DONE.
   task automatic run_verify(input logic [127:0] t, input logic [127:0] rx, input bit gaps,
                             input bit inject, output int done_cyc);
      int c, k;
      bit gap;
      start_i = 1'b1; mode_i = 1'b1; tag_i = t; rx_valid_i = 1'b0;
      ok_q.push_back(rx == t);
      tick();
      start_i = 1'b0;
      c = 1; k = 0; gap = 1'b0; done_cyc = -1;
      while (c < 60) begin
         if (done_o) begin done_cyc = c; break; end
         chk("verify_rx_ready", rx_ready_o, 1'b1);
         if (inject && c == 2) begin
            start_i = 1'b1; mode_i = 1'b0; tag_i = ~t;
         end else begin
            start_i = 1'b0;
         end
         if (gap || k >= int'(NW)) begin
            rx_valid_i = 1'b0;
            gap = 1'b0;
         end else begin
            rx_valid_i = 1'b1;
            rx_word_i = rx[127 - k*W -: W];
            k++;
            gap = gaps;
         end
         tick();
         c++;
      end
      rx_valid_i = 1'b0;
      start_i = 1'b0;
      if (done_cyc < 0) chk("verify_done_seen", done_o, 1'b1);
      chk("verify_done_busy", busy_o, 1'b1);
      chk("verify_done_rx_ready", rx_ready_o, 1'b0);
      if (inject) begin
         start_i = 1'b1; mode_i = 1'b0; tag_i = ~t;
      end
      tick();
      start_i = 1'b0;
      chk("verify_done_pulse", done_o, 1'b0);
      chk("verify_after_busy", busy_o, 1'b0);
      chk("verify_tag_ok", tag_ok_o, ok_q.pop_front());
      for (int i = 0; i < 3; i++) tick();
      chk("verify_no_restart", busy_o, 1'b0);
      chk("verify_tag_ok_held", tag_ok_o, (rx == t));
   endtask

   initial begin
      int d0, d1, dm, dx;
      reset_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; tag_i = '0;
      word_ready_i = 1'b0; rx_word_i = '0; rx_valid_i = 1'b0;
      tick(); tick();
      reset_i = 1'b0;
      chk_idle_outputs("reset");

      // EMIT without back-pressure: done at cycle NB_WORDS+1.
      run_emit(T, -1, 0, d0);
      chk("emit_latency", d0, NW + 1);

      // EMIT with 3 stall cycles on word 2.
      run_emit(T, 2, 3, d1);
      chk("emit_stall_latency", d1, NW + 1 + 3);

      // VERIFY match with 1-cycle gaps.
      run_verify(T, T, 1'b1, 1'b0, dm);
      chk("verify_match_latency", dm, 2*NW);

      // Reset from idle clears the held result.
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      chk("reset_clears_tag_ok", tag_ok_o, 1'b0);

      // VERIFY mismatch in word 0 only; same timing as the match.
      run_verify(T, {32'h01234566, T[95:0]}, 1'b1, 1'b0, dx);
      chk("verify_mismatch_latency", dx, dm);

      // start_i during CHECK and DONE is ignored.
      run_verify(T2, T2, 1'b0, 1'b1, dx);
      chk("verify_inject_latency", dx, NW + 1);

      // Reset mid-SEND after two words.
      start_i = 1'b1; mode_i = 1'b0; tag_i = T; word_ready_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick(); tick();
      chk("midsend_word2", word_o, T[63:32]);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      chk_idle_outputs("midsend_reset");
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("midsend_no_done", done_o, 1'b0);
      end

      // New start works after the abort.
      run_emit(T2, -1, 0, d0);
      chk("post_reset_latency", d0, NW + 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
